// File: rtl/tx_phy_mc.sv
// tx_phy_mc: parametrised multi-lane Alink transmit PHY.
//
// Pops one frame from a first-word-fall-through TxFIFO (TASKID_LEN header words, then DATA_LEN
// hash words), appends a self-generated nonce sweep (0, step, 2*step, ... below 2^32) and
// serialises everything with return-to-zero symbols on the selected lanes.
// A start symbol (00) lasts T cycles. Each bit is {b,~b} for T cycles followed by 00 for T
// cycles, sent LSB first. T = max(reg_timing+1, TASKID_LEN+1) and is latched at frame start.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   reg_flush       synchronous abort back to idle (no done / err pulse)
//   reg_timing      bit period minus one
//   tx_phy_start    frame request pulse (ignored while busy)
//   tx_phy_sel      lane select, sampled with tx_phy_start
//   tx_phy_done     1-cycle pulse in the last cycle of a frame
//   tx_phy_err      1-cycle pulse after a pop was due with the FIFO empty
//   tx_busy         high whenever the FSM is not idle
//   tx_dout         FIFO head word
//   tx_empty        FIFO empty flag
//   tx_rd_en        FIFO pop
//   task_id_vld     1-cycle pulse, header registers valid
//   rx_phy_sel      latched lane select
//   task_id_h/l     header words 0 and 1
//   reg_tout        header word 3
//   TX_P, TX_N      lane outputs, idle 11
module tx_phy_mc #(
  parameter int unsigned PHY_NUM    = 32,
  parameter logic [31:0] PHY_EN     = 32'h0000_03FF,
  parameter int unsigned TIMING_W   = 8,
  parameter int unsigned TASKID_LEN = 4,
  parameter int unsigned DATA_LEN   = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reg_flush,
  input  logic [TIMING_W-1:0] reg_timing,
  input  logic                tx_phy_start,
  input  logic [PHY_NUM-1:0]  tx_phy_sel,
  output logic                tx_phy_done,
  output logic                tx_phy_err,
  output logic                tx_busy,
  input  logic [31:0]         tx_dout,
  input  logic                tx_empty,
  output logic                tx_rd_en,
  output logic                task_id_vld,
  output logic [PHY_NUM-1:0]  rx_phy_sel,
  output logic [31:0]         task_id_h,
  output logic [31:0]         task_id_l,
  output logic [31:0]         reg_tout,
  output logic [PHY_NUM-1:0]  TX_P,
  output logic [PHY_NUM-1:0]  TX_N
);

  // One extra bit so that T-1 = TASKID_LEN always fits next to a full-range reg_timing.
  localparam int unsigned CW = (TIMING_W + 1 > $clog2(TASKID_LEN + 2)) ? TIMING_W + 1
                                                                       : $clog2(TASKID_LEN + 2);
  localparam int unsigned WW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  localparam logic [CW-1:0] HdrLast  = CW'(TASKID_LEN);
  localparam logic [CW-1:0] HdrVld   = CW'(TASKID_LEN - 1);
  localparam logic [WW-1:0] DataLast = WW'(DATA_LEN - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StNonce} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;     // cycle within the current T period (HDR: cycle since frame start)
  logic [CW-1:0] tlast_q;   // T-1
  logic          zero_q;    // second half of a bit (00 symbol)
  logic [4:0]    bit_q;
  logic [WW-1:0] word_q;
  logic [31:0]   shift_q;   // word on the line, current bit in [0]
  logic [32:0]   acc_q;     // nonce accumulator
  logic [31:0]   reg_step_q;
  logic [1:0]    line_q;    // {P,N} driven on enabled, selected lanes

  logic          period_end, word_end, last_data;
  logic          hdr_due, data_due, pop_due, underflow;
  logic [32:0]   acc_next;
  logic          nonce_last, done_next;
  logic [31:0]   first_word;
  logic [CW-1:0] t_next;
  logic [PHY_NUM-1:0] lane_mask;

  always_comb begin
    period_end = (cnt_q == tlast_q);
    word_end   = zero_q && (bit_q == 5'd31) && period_end;
    last_data  = (word_q == DataLast);
    hdr_due    = (state_q == StHdr) && (cnt_q <= HdrLast);
    // The next hash word is fetched in the very last cycle of the current word.
    data_due   = (state_q == StData) && word_end && !last_data;
    pop_due    = hdr_due || data_due;
    underflow  = pop_due && tx_empty;
    tx_rd_en   = pop_due && !tx_empty && !reg_flush;
    acc_next   = acc_q + {1'b0, reg_step_q};
    // A zero step would never leave the 32-bit range, so it sends exactly one word.
    nonce_last = (reg_step_q == 32'h0) || acc_next[32];
    // done is registered, so it is raised one cycle ahead of the frame's final cycle (T >= 5).
    done_next  = (state_q == StNonce) && zero_q && (bit_q == 5'd31) && nonce_last &&
                 (cnt_q == tlast_q - CW'(1));
    // When T-1 == TASKID_LEN the first data word is popped in the same cycle HDR ends.
    first_word = (cnt_q == HdrLast) ? tx_dout : shift_q;
    t_next     = (CW'(reg_timing) >= HdrLast) ? CW'(reg_timing) : HdrLast;
  end

  assign tx_busy   = (state_q != StIdle);
  assign lane_mask = rx_phy_sel & PHY_EN[PHY_NUM-1:0];
  assign TX_P      = ~lane_mask | {PHY_NUM{line_q[1]}};
  assign TX_N      = ~lane_mask | {PHY_NUM{line_q[0]}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tlast_q     <= '0;
      zero_q      <= 1'b0;
      bit_q       <= '0;
      word_q      <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      reg_step_q  <= '0;
      line_q      <= 2'b11;
      tx_phy_done <= 1'b0;
      tx_phy_err  <= 1'b0;
      task_id_vld <= 1'b0;
      rx_phy_sel  <= '0;
      task_id_h   <= '0;
      task_id_l   <= '0;
      reg_tout    <= '0;
    end else begin
      tx_phy_done <= 1'b0;
      tx_phy_err  <= 1'b0;
      task_id_vld <= 1'b0;
      if (reg_flush || underflow) begin
        // Header registers are deliberately left alone.
        tx_phy_err <= !reg_flush;
        state_q    <= StIdle;
        line_q     <= 2'b11;
        cnt_q      <= '0;
        zero_q     <= 1'b0;
        bit_q      <= '0;
        word_q     <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (tx_phy_start) begin
              rx_phy_sel <= tx_phy_sel;
              tlast_q    <= t_next;
              cnt_q      <= '0;
              zero_q     <= 1'b0;
              state_q    <= StHdr;
              line_q     <= 2'b00;
            end
          end
          StHdr: begin
            if (hdr_due) begin
              if (cnt_q == CW'(0)) task_id_h  <= tx_dout;
              if (cnt_q == CW'(1)) reg_step_q <= tx_dout;
              if (cnt_q == CW'(1)) task_id_l  <= tx_dout;
              if (cnt_q == CW'(2)) reg_step_q <= tx_dout;
              if (cnt_q == CW'(3)) reg_tout   <= tx_dout;
              if (cnt_q == HdrLast) shift_q   <= tx_dout;
              if (cnt_q == HdrVld) task_id_vld <= 1'b1;
            end
            if (period_end) begin
              cnt_q   <= '0;
              state_q <= StData;
              bit_q   <= '0;
              zero_q  <= 1'b0;
              word_q  <= '0;
              shift_q <= first_word;
              line_q  <= {first_word[0], ~first_word[0]};
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          StData, StNonce: begin
            tx_phy_done <= done_next;
            if (!period_end) begin
              cnt_q <= cnt_q + CW'(1);
            end else begin
              cnt_q <= '0;
              if (!zero_q) begin
                zero_q <= 1'b1;
                line_q <= 2'b00;
              end else if (bit_q != 5'd31) begin
                zero_q  <= 1'b0;
                bit_q   <= bit_q + 5'd1;
                shift_q <= shift_q >> 1;
                line_q  <= {shift_q[1], ~shift_q[1]};
              end else begin
                zero_q <= 1'b0;
                bit_q  <= '0;
                if (state_q == StData) begin
                  if (last_data) begin
                    state_q <= StNonce;
                    acc_q   <= '0;
                    shift_q <= '0;
                    line_q  <= 2'b01;
                  end else begin
                    word_q  <= word_q + WW'(1);
                    shift_q <= tx_dout;
                    line_q  <= {tx_dout[0], ~tx_dout[0]};
                  end
                end else if (nonce_last) begin
                  state_q <= StIdle;
                  line_q  <= 2'b11;
                end else begin
                  acc_q   <= acc_next;
                  shift_q <= acc_next[31:0];
                  line_q  <= {acc_next[0], ~acc_next[0]};
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/tx_phy_mc.md
Name: tx_phy_mc

Overview:
Parametrised multi-lane Alink transmit PHY, the successor to the fixed 32-lane TX PHY. It pops a frame from the TxFIFO: a task header, DATA_LEN hash words, then a self-generated nonce sweep. It serialises the frame onto up to PHY_NUM differential lanes using return-to-zero symbol encoding. New relative to the previous generation:
- runtime bit period
- lane-presence mask parameter
- FIFO-underflow error detection
- true flush abort of the FSM
- defined handling of a step value of 0

Parameters:
PHY_NUM, 32, number of lanes (1..32).
PHY_EN, 32'h0000_03FF, lane-present mask; lanes with a 0 bit are tied to idle 11.
TIMING_W, 8, width of reg_timing and the period counter.
TASKID_LEN, 4, header words popped per frame (>=4; words beyond 4 are discarded).
DATA_LEN, 23, hash words per frame.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
reg_flush  in  1  synchronous abort
reg_timing  in  TIMING_W  bit period minus 1; latched on frame start
tx_phy_start  in  1  frame request pulse
tx_phy_sel  in  PHY_NUM  lane select, sampled with start
tx_phy_done  out  1  1-cycle pulse, frame complete
tx_phy_err  out  1  1-cycle pulse, FIFO underflow abort
tx_busy  out  1  high whenever FSM != IDLE
tx_dout  in  32  TxFIFO first-word-fall-through data
tx_empty  in  1  TxFIFO empty
tx_rd_en  out  1  TxFIFO pop
task_id_vld  out  1  1-cycle pulse, header registers valid
rx_phy_sel  out  PHY_NUM  latched lane select
task_id_h, task_id_l, reg_tout  out  32 each  header words 0, 1, 3
TX_P, TX_N  out  PHY_NUM each  lane outputs

Behaviour:
- Reset values: all outputs 0, except TX_P and TX_N which are all 1. Internal reg_step is 0. FSM is IDLE.
- Period T = max(reg_timing+1, TASKID_LEN+1), latched at start.
- Lane output: lane i = {Px,Nx} if rx_phy_sel[i] and PHY_EN[i], otherwise 11.
- Symbols:
  - idle = 11
  - start = 00 for T cycles
  - each bit = data symbol {b,~b} for T cycles, then 00 for T cycles
  - bits are sent LSB first, 32 bits per word
- FSM states: IDLE, HDR, DATA, NONCE.
- IDLE:
  - tx_phy_start → latch tx_phy_sel and reg_timing; enter HDR next cycle (cycle 0).
  - Px/Nx go 00 at cycle 0.
  - tx_phy_start is ignored when not in IDLE.
- HDR:
  - Pops on cycles 0..TASKID_LEN-1.
  - Header word 0 → task_id_h, 1 → task_id_l, 2 → reg_step, 3 → reg_tout.
  - Data word 0 is popped at cycle TASKID_LEN. task_id_vld pulses in the same cycle, with task_id_h/task_id_l/reg_step/reg_tout already updated.
  - First data symbol at cycle T; enter DATA.
- Pop rule: tx_rd_en asserts only when tx_empty=0.
  - If a pop is due while tx_empty=1: tx_phy_err pulses next cycle, lines return to 11, FSM goes to IDLE, no tx_phy_done.
- DATA:
  - The next word pops in the last cycle of the current word's final 00 period.
  - After DATA_LEN words, enter NONCE with no gap on the line.
- NONCE:
  - Words n0=0, n(k+1)=n(k)+reg_step, computed in a 33-bit accumulator.
  - The last word sent is the last value below 2^32.
  - reg_step=0 → exactly one nonce word (0).
  - No FIFO pops in NONCE.
- End of frame:
  - In the last cycle of the final 00 period, tx_phy_done pulses.
  - Lines go to 11 on the following cycle; FSM to IDLE.
- Frame length from HDR cycle 0 to done inclusive = T*(1 + 64*(DATA_LEN+Nn)), where Nn is the nonce word count.
- reg_flush in any state:
  - next cycle: FSM IDLE, lines 11, period/bit/word counters cleared
  - no done, no err pulse
  - header registers keep their values
- Priority: rst > reg_flush > underflow > normal operation.
- rst mid-frame behaves as reset, asynchronously.

Test Plan:
- Header and frame timing: PHY_NUM=32, DATA_LEN=2, reg_timing=7, sel=0x5, header {0xA,0xB,0x8000_0000,0x10}, data {1,0}.
  - 00 on lanes 0 and 2 only from cycle 0; all other lanes 11.
  - task_id_vld at cycle 4 with h=0xA, l=0xB, reg_tout=0x10.
  - Nn=2; done at cycle 8+256*8-1=2055.
- Bit encoding: same frame. Lane 0 shows:
  - cycles 8–15 = 10
  - cycles 16–23 = 00
  - cycles 24–31 = 01
- Underflow: tx_empty=1 when data word 1 is due → tx_phy_err pulse, lines 11, tx_busy=0, no done.
- Flush: reg_flush during NONCE → IDLE and lines 11 next cycle, no done; a following tx_phy_start runs a normal frame.
- Period clamp and step 0: reg_timing=1, TASKID_LEN=4 → T=5. reg_step=0 → one nonce word; frame length 5*(1+64*3)=965 cycles.
- Start while busy: tx_phy_start mid-DATA is ignored, and rx_phy_sel is unchanged. A lane with PHY_EN=0 stays 11 even when selected.
